// File: rtl/dma_cmd_queue_if.sv
// Command-side and engine-side signal bundle for the DMA command queue.
interface dma_cmd_queue_if #(
    parameter int unsigned ADDRWIDTH      = 8,
    parameter int unsigned DMEM_ADDRWIDTH = 32,
    parameter int unsigned DEPTH          = 4
);
    localparam int unsigned CNTW = $clog2(DEPTH) + 1;

    // core -> queue command channel
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [DMEM_ADDRWIDTH-1:0] cmd_mem_addr;
    logic [ADDRWIDTH-1:0]      cmd_lane_addr;
    logic [15:0]               cmd_len;
    logic                      cmd_we;

    // queue -> engine chunk request and engine status
    logic [DMEM_ADDRWIDTH-1:0] dma_mem_addr;
    logic [7:0]                dma_num_bytes;
    logic [ADDRWIDTH-1:0]      dma_lane_addr;
    logic                      dma_we;
    logic                      dma_en;
    logic                      dma_busy;

    // status back to the core
    logic [CNTW-1:0]           q_count;
    logic                      busy;
    logic                      cmd_done;
    logic                      cmd_err;

    // queue side
    modport slave (
        input  cmd_valid, cmd_mem_addr, cmd_lane_addr, cmd_len, cmd_we, dma_busy,
        output cmd_ready, dma_mem_addr, dma_num_bytes, dma_lane_addr, dma_we, dma_en,
               q_count, busy, cmd_done, cmd_err
    );

    // core / engine side
    modport master (
        output cmd_valid, cmd_mem_addr, cmd_lane_addr, cmd_len, cmd_we, dma_busy,
        input  cmd_ready, dma_mem_addr, dma_num_bytes, dma_lane_addr, dma_we, dma_en,
               q_count, busy, cmd_done, cmd_err
    );
endinterface

// File: rtl/dma_cmd_queue.sv
// DMA command queue: buffers core commands, splits them into engine-sized
// chunks and runs the dma_en / dma_busy handshake one chunk at a time.
module dma_cmd_queue #(
    parameter int unsigned NUMLANES       = 8,
    parameter int unsigned WIDTH          = 16,
    parameter int unsigned ADDRWIDTH      = 8,
    parameter int unsigned DMEM_ADDRWIDTH = 32,
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned MAX_CHUNK      = 128
) (
    input  logic           clk,
    input  logic           reset,
    dma_cmd_queue_if.slave bus
);
    localparam int unsigned LINE_BYTES = NUMLANES * WIDTH / 8;
    localparam int unsigned PTRW       = $clog2(DEPTH);
    localparam int unsigned CNTW       = $clog2(DEPTH) + 1;
    localparam int unsigned LENW       = 16;
    localparam int unsigned CHUNKW     = 8;

    typedef struct packed {
        logic [DMEM_ADDRWIDTH-1:0] mem;
        logic [ADDRWIDTH-1:0]      lane;
        logic [LENW-1:0]           len;
        logic                      we;
    } cmd_t;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD       = 3'd1,
        ISSUE      = 3'd2,
        WAIT_START = 3'd3,
        WAIT_DONE  = 3'd4
    } state_t;

    cmd_t                      fifo_mem [DEPTH];
    cmd_t                      head;
    logic [PTRW-1:0]           wr_ptr;
    logic [PTRW-1:0]           rd_ptr;
    logic [CNTW-1:0]           count;
    logic [CNTW-1:0]           count_nx;

    state_t                    state;
    state_t                    state_nx;
    logic [DMEM_ADDRWIDTH-1:0] cur_mem;
    logic [DMEM_ADDRWIDTH-1:0] cur_mem_nx;
    logic [ADDRWIDTH-1:0]      cur_lane;
    logic [ADDRWIDTH-1:0]      cur_lane_nx;
    logic [LENW-1:0]           rem;
    logic [LENW-1:0]           rem_nx;
    logic [CHUNKW-1:0]         chunk;
    logic [CHUNKW-1:0]         chunk_nx;
    logic                      cur_we;
    logic                      cur_we_nx;

    logic                      dma_en_q;
    logic                      dma_en_nx;
    logic                      done_q;
    logic                      done_nx;
    logic                      err_q;
    logic                      ready_q;
    logic                      busy_q;

    logic                      len_ok;
    logic                      push;
    logic                      push_ok;
    logic                      pop;

    // Size of the next engine transfer for a given remaining length.
    function automatic logic [CHUNKW-1:0] chunk_of(input logic [LENW-1:0] r);
        return (r > LENW'(MAX_CHUNK)) ? CHUNKW'(MAX_CHUNK) : CHUNKW'(r);
    endfunction

    assign head    = fifo_mem[rd_ptr];
    assign len_ok  = (bus.cmd_len != '0) && ((bus.cmd_len % LENW'(LINE_BYTES)) == '0);
    assign push    = bus.cmd_valid & ready_q;
    assign push_ok = push & len_ok;

    // Next-state and next-value logic for the chunking FSM and FIFO occupancy.
    always_comb begin
        state_nx    = state;
        cur_mem_nx  = cur_mem;
        cur_lane_nx = cur_lane;
        rem_nx      = rem;
        chunk_nx    = chunk;
        cur_we_nx   = cur_we;
        dma_en_nx   = 1'b0;
        done_nx     = 1'b0;
        pop         = 1'b0;

        unique case (state)
            IDLE: begin
                if (count != '0) state_nx = LOAD;
            end
            LOAD: begin
                cur_mem_nx  = head.mem;
                cur_lane_nx = head.lane;
                rem_nx      = head.len;
                cur_we_nx   = head.we;
                chunk_nx    = chunk_of(head.len);
                dma_en_nx   = 1'b1;
                state_nx    = ISSUE;
            end
            ISSUE: begin
                state_nx = WAIT_START;
            end
            WAIT_START: begin
                if (bus.dma_busy) state_nx = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!bus.dma_busy) begin
                    cur_mem_nx  = cur_mem + DMEM_ADDRWIDTH'(chunk);
                    cur_lane_nx = cur_lane + ADDRWIDTH'(chunk / CHUNKW'(LINE_BYTES));
                    rem_nx      = rem - LENW'(chunk);
                    chunk_nx    = chunk_of(rem_nx);
                    if (rem_nx != '0) begin
                        dma_en_nx = 1'b1;
                        state_nx  = ISSUE;
                    end else begin
                        pop      = 1'b1;
                        done_nx  = 1'b1;
                        state_nx = IDLE;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        count_nx = count + CNTW'(push_ok) - CNTW'(pop);
    end

    // State, pointers and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            cur_mem  <= '0;
            cur_lane <= '0;
            rem      <= '0;
            chunk    <= '0;
            cur_we   <= 1'b0;
            dma_en_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_nx;
            cur_mem  <= cur_mem_nx;
            cur_lane <= cur_lane_nx;
            rem      <= rem_nx;
            chunk    <= chunk_nx;
            cur_we   <= cur_we_nx;
            dma_en_q <= dma_en_nx;
            done_q   <= done_nx;
            err_q    <= push & ~len_ok;
            count    <= count_nx;
            ready_q  <= (count_nx < CNTW'(DEPTH));
            busy_q   <= (count_nx != '0) || (state_nx != IDLE);
            if (push_ok) wr_ptr <= wr_ptr + PTRW'(1);
            if (pop)     rd_ptr <= rd_ptr + PTRW'(1);
        end
    end

    // Command storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= '{mem: bus.cmd_mem_addr, lane: bus.cmd_lane_addr,
                                  len: bus.cmd_len, we: bus.cmd_we};
        end
    end

    assign bus.cmd_ready     = ready_q;
    assign bus.dma_mem_addr  = cur_mem;
    assign bus.dma_num_bytes = chunk;
    assign bus.dma_lane_addr = cur_lane;
    assign bus.dma_we        = cur_we;
    assign bus.dma_en        = dma_en_q;
    assign bus.q_count       = count;
    assign bus.busy          = busy_q;
    assign bus.cmd_done      = done_q;
    assign bus.cmd_err       = err_q;
endmodule
